axi_conv_fp_3x3: RTL and testbench
==================================

Name: axi_conv_fp_3x3

Overview:
- Streaming 3x3 convolution over a fixed-size image of signed fixed-point pixels.
- Pixels arrive raster-order (row-major) on an AXI4-Stream slave port.
- One result per fully-valid 3x3 window is emitted on an AXI4-Stream master port: "valid" border handling, (M-2)x(N-2) outputs per frame.
- Sits between a DMA MM2S channel and an S2MM channel.

Parameters:
- DATA_WIDTH, 32, pixel/result width (signed two's complement).
- FRAC_BITS, 24, fractional bits of pixels, coefficients and results (Q8.24).
- IMG_ROWS, 480, image rows M (>=3).
- IMG_COLS, 640, image columns N (>=3).
- K0..K8, Q8.24 kernel coefficients, row-major, K0 top-left. Defaults: 1/16, 2/16, 1/16, 2/16, 4/16, 2/16, 1/16, 2/16, 1/16 (0x00100000, 0x00200000, 0x00100000, 0x00200000, 0x00400000, ...).

Ports:
- s_axis_aclk  in  1  sole clock; all logic on rising edge.
- s_axis_aresetn  in  1  asynchronous active-low reset.
- m_axis_aclk  in  1  must be tied to s_axis_aclk; unused internally.
- m_axis_aresetn  in  1  asynchronous active-low reset; internal reset = s_axis_aresetn AND m_axis_aresetn.
- Start  in  1  level enable; 0 = accept no input.
- s_axis_tdata  in  32  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  convolution result.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  marks last result of a frame.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Row/col counters = 0; line buffers and window contents are don't-care.
  - s_axis_tready is combinational and reads 0 while Start=0.
- s_axis_tready = Start AND (NOT m_axis_tvalid OR m_axis_tready).
- Accept = s_axis_tvalid AND s_axis_tready. Nothing advances without accept; a stalled pipeline holds all state.
- On accept of pixel (r,c):
  - Shift pixel into two line buffers of IMG_COLS words, providing rows r-2, r-1, r at column c.
  - Shift the 3x3 window left; the new right column is {row r-2, row r-1, row r} at column c.
  - Advance col; on col=N-1, wrap col to 0 and increment row; on row=M-1 and col=N-1, wrap both to 0 (next frame starts cleanly).
- Window completes when r>=2 AND c>=2. The output covers input rows r-2..r and columns c-2..c.
- Output register:
  - On the clock edge of a completing accept: m_axis_tdata = result, m_axis_tvalid=1.
  - m_axis_tlast=1 iff r=M-1 AND c=N-1.
  - Latency is 1 clock from accept to valid.
  - Else, if m_axis_tready: m_axis_tvalid=0, m_axis_tlast=0.
  - A held output is stable until taken (AXI rule).
- Arithmetic:
  - 9 signed 32x32 products (64-bit), summed at >=68 bits.
  - Arithmetic shift right FRAC_BITS (truncate toward -inf).
  - Saturate to [0x80000000, 0x7FFFFFFF].
- Start: when 0 with input mid-frame, acceptance pauses and counters hold. A pending output can still drain.
- Windows spanning a row wrap (c<2) are never emitted. Exactly (M-2)*(N-2) results per frame; frame N+1 results do not depend on frame N data.
- Reset mid-frame: everything restarts at (0,0); partial frame discarded, no tlast.

Test Plan:
- M=N=5, default kernel, all pixels 0x01000000 (1.0) -> 9 outputs, each 0x01000000; tlast only on 9th.
- M=N=5, kernel K4=0x01000000 and others 0, pixel(r,c)=(5r+c)<<24 -> outputs (5r+c)<<24 for r,c in 1..3, in order 6,7,8,11,...,18 (x2^24).
- Saturation: kernel all 0x01000000, pixels 0x7FFFFFFF -> every output 0x7FFFFFFF; pixels 0x80000000 -> 0x80000000.
- Backpressure: m_axis_tready toggling 1010... -> s_axis_tready drops while output is held; sequence identical to no-stall run; tdata stable while valid & !ready.
- Start=0 after 7 pixels, then 1 -> tready=0 during pause, no outputs lost or duplicated; two back-to-back frames each give 9 results with one tlast each.
- Reset asserted after 12 pixels, then full frame -> only 9 outputs, all from the new frame.

Source files
------------

// File: rtl/axi_conv_fp_3x3.sv
// Streaming 3x3 fixed-point convolution over a raster image, AXI4-Stream in and out.
// Only fully-valid windows are emitted; a frame yields (IMG_ROWS-2)*(IMG_COLS-2) results.
module axi_conv_fp_3x3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 24,
  parameter int unsigned IMG_ROWS   = 480,
  parameter int unsigned IMG_COLS   = 640,
  parameter logic [DATA_WIDTH-1:0] K0 = 32'h0010_0000,
  parameter logic [DATA_WIDTH-1:0] K1 = 32'h0020_0000,
  parameter logic [DATA_WIDTH-1:0] K2 = 32'h0010_0000,
  parameter logic [DATA_WIDTH-1:0] K3 = 32'h0020_0000,
  parameter logic [DATA_WIDTH-1:0] K4 = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] K5 = 32'h0020_0000,
  parameter logic [DATA_WIDTH-1:0] K6 = 32'h0010_0000,
  parameter logic [DATA_WIDTH-1:0] K7 = 32'h0020_0000,
  parameter logic [DATA_WIDTH-1:0] K8 = 32'h0010_0000
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = 2 * DW + 4;
  localparam int unsigned HW = SW - DW + 1;
  localparam int unsigned RW = (IMG_ROWS > 2) ? $clog2(IMG_ROWS) : 2;
  localparam int unsigned CW = (IMG_COLS > 2) ? $clog2(IMG_COLS) : 2;
  localparam logic [DW-1:0] KC [9] = '{K0, K1, K2, K3, K4, K5, K6, K7, K8};

  logic clk;
  logic rst_n;
  logic unused_m_aclk;

  assign clk           = s_axis_aclk;
  assign rst_n         = s_axis_aresetn & m_axis_aresetn;
  assign unused_m_aclk = m_axis_aclk;

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [DW-1:0] lb1_q [IMG_COLS];
  logic [DW-1:0] lb2_q [IMG_COLS];
  logic [DW-1:0] win_q [9];
  logic [DW-1:0] win_d [9];

  logic                 accept_c;
  logic                 last_col_c;
  logic                 last_row_c;
  logic                 win_done_c;
  logic signed [PW-1:0] prod_c;
  logic signed [SW-1:0] acc_c;
  logic signed [SW-1:0] shr_c;
  logic        [HW-1:0] hi_c;
  logic        [DW-1:0] res_c;

  logic          tvalid_q;
  logic          tlast_q;
  logic [DW-1:0] tdata_q;

  assign s_axis_tready = Start & (~tvalid_q | m_axis_tready);
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;

  // Raster position of the pixel currently on the input bus.
  always_comb begin
    accept_c   = s_axis_tvalid & s_axis_tready;
    last_col_c = (col_q == CW'(IMG_COLS - 1));
    last_row_c = (row_q == RW'(IMG_ROWS - 1));
    win_done_c = (row_q >= RW'(2)) && (col_q >= CW'(2));
    row_d      = row_q;
    col_d      = col_q;
    if (accept_c) begin
      if (last_col_c) begin
        col_d = '0;
        row_d = last_row_c ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window as it will look after this accept: shifted left, new column on the right.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_d[3*i]     = win_q[3*i+1];
      win_d[3*i + 1] = win_q[3*i+2];
      win_d[3*i + 2] = '0;
    end
    win_d[2] = lb2_q[col_q];
    win_d[5] = lb1_q[col_q];
    win_d[8] = s_axis_tdata;
  end

  // Multiply-accumulate with wide headroom, rescale, then saturate to the pixel range.
  always_comb begin
    acc_c  = '0;
    prod_c = '0;
    for (int i = 0; i < 9; i++) begin
      prod_c = PW'($signed(win_d[i])) * PW'($signed(KC[i]));
      acc_c  = acc_c + SW'(prod_c);
    end
    shr_c = acc_c >>> FRAC_BITS;
    hi_c  = shr_c[SW-1:DW-1];
    if ((&hi_c) || !(|hi_c)) begin
      res_c = shr_c[DW-1:0];
    end else if (shr_c[SW-1]) begin
      res_c = {1'b1, {(DW-1){1'b0}}};
    end else begin
      res_c = {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      col_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      if (accept_c && win_done_c) begin
        tdata_q  <= res_c;
        tvalid_q <= 1'b1;
        tlast_q  <= last_row_c & last_col_c;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  // Line buffers and window carry no reset; counters guarantee they refill before use.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= s_axis_tdata;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

endmodule

// File: tb/tb_axi_conv_fp_3x3.sv
// Three kernels (default, identity, all-ones) share one stimulus stream on a 5x5 image;
// each output is compared against a plain-arithmetic convolution of the accepted pixels.
module tb_axi_conv_fp_3x3;

  localparam int M = 5;
  localparam int N = 5;

  logic clk;
  logic s_rst_n, m_rst_n, start, s_tvalid, m_tready;
  logic [31:0] s_tdata;
  logic [2:0] s_tready, m_tvalid, m_tlast;
  logic [2:0][31:0] m_tdata;

  int total, bad;
  int drv_idx, gap_pct, rdy_mode;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   img [M][N];
  int   mr, mc, outs_in_frame;
  logic hold_pend;
  exp_t held;

  axi_conv_fp_3x3 #(.DATA_WIDTH(32), .FRAC_BITS(24), .IMG_ROWS(M), .IMG_COLS(N)) u_dut (
    .s_axis_aclk(clk), .s_axis_aresetn(s_rst_n), .m_axis_aclk(clk), .m_axis_aresetn(m_rst_n),
    .Start(start), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast[0]));

  axi_conv_fp_3x3 #(.DATA_WIDTH(32), .FRAC_BITS(24), .IMG_ROWS(M), .IMG_COLS(N),
    .K0(32'h0), .K1(32'h0), .K2(32'h0), .K3(32'h0), .K4(32'h0100_0000),
    .K5(32'h0), .K6(32'h0), .K7(32'h0), .K8(32'h0)) u_dut_id (
    .s_axis_aclk(clk), .s_axis_aresetn(s_rst_n), .m_axis_aclk(clk), .m_axis_aresetn(m_rst_n),
    .Start(start), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast[1]));

  axi_conv_fp_3x3 #(.DATA_WIDTH(32), .FRAC_BITS(24), .IMG_ROWS(M), .IMG_COLS(N),
    .K0(32'h0100_0000), .K1(32'h0100_0000), .K2(32'h0100_0000), .K3(32'h0100_0000),
    .K4(32'h0100_0000), .K5(32'h0100_0000), .K6(32'h0100_0000), .K7(32'h0100_0000),
    .K8(32'h0100_0000)) u_dut_sat (
    .s_axis_aclk(clk), .s_axis_aresetn(s_rst_n), .m_axis_aclk(clk), .m_axis_aresetn(m_rst_n),
    .Start(start), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[2]),
    .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic int kval(input int kid, input int i);
    case (kid)
      0:       return (i == 4) ? 32'h0040_0000 : ((i % 2) == 1) ? 32'h0020_0000 : 32'h0010_0000;
      1:       return (i == 4) ? 32'h0100_0000 : 0;
      default: return 32'h0100_0000;
    endcase
  endfunction

  // Exact convolution of the window ending at (r,c), then floor-shift and clamp.
  function automatic logic [31:0] ref_conv(input int kid, input int r, input int c);
    logic signed [127:0] acc, a, b;
    acc = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        a   = 128'(signed'(img[r-2+dr][c-2+dc]));
        b   = 128'(signed'(kval(kid, dr*3 + dc)));
        acc = acc + a * b;
      end
    end
    acc = acc >>> 24;
    if (acc > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -(128'sd2147483648)) return 32'h8000_0000;
    return acc[31:0];
  endfunction

  function automatic logic [31:0] pix_val(input int mode, input int idx);
    int r, c;
    r = idx / N;
    c = idx % N;
    case (mode)
      0:       return 32'h0100_0000;
      1:       return 32'(N*r + c) << 24;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 32'h07FF_FFFF)) - 32'h0400_0000;
      default: return $urandom;
    endcase
  endfunction

  // Downstream ready pattern: always, alternating, or random.
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = !m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!(s_rst_n && m_rst_n)) begin
      mr = 0;
      mc = 0;
      exp_q.delete();
      hold_pend = 1'b0;
      outs_in_frame = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        check_eq("s_tready", 32'(s_tready[k]), 32'(start && (!m_tvalid[k] || m_tready)));
        check_eq("tvalid", 32'(m_tvalid[k]), 32'(exp_q.size() > 0));
      end
      if (hold_pend) begin
        check_eq("hold_d0", m_tdata[0], held.d0);
        check_eq("hold_d1", m_tdata[1], held.d1);
        check_eq("hold_d2", m_tdata[2], held.d2);
        check_eq("hold_last", 32'(m_tlast[0]), 32'(held.last));
      end
      hold_pend = 1'b0;
      if (m_tready && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("out_dflt", m_tdata[0], e.d0);
        check_eq("out_ident", m_tdata[1], e.d1);
        check_eq("out_ones", m_tdata[2], e.d2);
        for (int k = 0; k < 3; k++) check_eq("out_tlast", 32'(m_tlast[k]), 32'(e.last));
        outs_in_frame++;
        if (e.last) begin
          check_eq("frame_count", 32'(outs_in_frame), 32'((M-2)*(N-2)));
          outs_in_frame = 0;
        end
      end else if (exp_q.size() > 0) begin
        hold_pend = 1'b1;
        held = exp_q[0];
      end
      if (s_tvalid && s_tready[0]) begin
        img[mr][mc] = int'(s_tdata);
        if (mr >= 2 && mc >= 2) begin
          exp_t e;
          e.d0 = ref_conv(0, mr, mc);
          e.d1 = ref_conv(1, mr, mc);
          e.d2 = ref_conv(2, mr, mc);
          e.last = (mr == M-1) && (mc == N-1);
          exp_q.push_back(e);
        end
        if (mc == N-1) begin
          mc = 0;
          mr = (mr == M-1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end
    end
  end

  task automatic send_pix(input logic [31:0] v);
    int guard;
    while ($urandom_range(0, 99) < gap_pct) begin
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_tdata  = v;
    s_tvalid = 1'b1;
    guard    = 0;
    forever begin
      @(negedge clk);
      if (s_tready[0]) break;
      guard++;
      if (guard > 200) begin
        check_eq("accept_timeout", 32'(s_tready[0]), 32'd1);
        finish_run();
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    drv_idx  = (drv_idx + 1) % (M*N);
  endtask

  task automatic send_n(input int mode, input int count);
    for (int i = 0; i < count; i++) send_pix(pix_val(mode, drv_idx));
  endtask

  initial begin
    total = 0; bad = 0;
    s_rst_n = 1'b0; m_rst_n = 1'b0; start = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    gap_pct = 0; rdy_mode = 0; drv_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    s_rst_n = 1'b1; m_rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_tvalid", 32'(m_tvalid[k]), 32'd0);
      check_eq("rst_tdata", m_tdata[k], 32'd0);
      check_eq("rst_tlast", 32'(m_tlast[k]), 32'd0);
      check_eq("rst_tready", 32'(s_tready[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b1;

    send_n(0, M*N);
    send_n(1, M*N);
    send_n(2, M*N);
    send_n(3, M*N);

    rdy_mode = 1;
    send_n(1, M*N);
    rdy_mode = 0;

    // Pause mid-frame, then finish it and run another frame back to back.
    send_n(1, 7);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1;
    send_n(1, M*N - 7);
    send_n(0, M*N);

    // Reset mid-frame through the master-side reset.
    send_n(4, 12);
    m_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_rst_n = 1'b1;
    drv_idx = 0;
    send_n(1, M*N);

    rdy_mode = 2;
    gap_pct  = 30;
    for (int f = 0; f < 4; f++) send_n((f % 2 == 1) ? 5 : 4, M*N);
    rdy_mode = 0;
    gap_pct  = 0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    finish_run();
  end

endmodule
